// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the attached
// device and checks the device ACK. The PS/2 lines are open-drain, so the
// block only produces drive-low enables; the top level turns each enable
// into 1'b0 / 1'bz on the shared inout.
//
// Bit sequencing: the device's first falling edge after the host releases
// the clock is the cue to present D0. Falls 1..10 present D0..D7, parity and
// stop (stop=1 releases data). The 11th fall is the device ACK slot.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int FRAME_TIMEOUT  = 200000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int REQ_CYCLES = 16;
    localparam int MAX_A      = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_B      = (MAX_A > FRAME_TIMEOUT) ? MAX_A : FRAME_TIMEOUT;
    localparam int MAX_CYC    = (MAX_B > REQ_CYCLES) ? MAX_B : REQ_CYCLES;
    localparam int TMR_W      = $clog2(MAX_CYC + 1);
    localparam int FLT_W      = $clog2(FILTER_LEN + 1);

    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] REQ_LAST   = TMR_W'(REQ_CYCLES - 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(FRAME_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = {TMR_W{1'b1}};
    localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_REQ       = 4'd2,
        ST_RELEASE   = 4'd3,
        ST_SEND      = 4'd4,
        ST_ACK       = 4'd5,
        ST_WAIT_IDLE = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } state_t;

    // Odd parity: the result makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    logic             clk_meta_r;
    logic             clk_sync_r;
    logic             data_meta_r;
    logic             data_sync_r;
    logic [FLT_W-1:0] flt_cnt_r;
    logic             filt_clk_r;
    logic             filt_prev_r;
    logic             fall_s;

    state_t           state_r;
    state_t           next_state_s;
    logic [TMR_W-1:0] tmr_r;
    logic             reload_s;
    logic             tmr_clear_s;
    logic [3:0]       bit_cnt_r;
    logic [3:0]       bit_cnt_nx_s;
    logic [9:0]       sh_r;
    logic             accept_s;
    logic             data_oe_nx_s;

    logic             tx_ready_r;
    logic             busy_r;
    logic             clk_oe_r;
    logic             data_oe_r;
    logic             tx_done_r;
    logic             tx_error_r;

    assign fall_s      = filt_prev_r & ~filt_clk_r;
    assign accept_s    = tx_valid & tx_ready_r;
    assign tmr_clear_s = reload_s | (next_state_s != state_r);

    assign tx_ready    = tx_ready_r;
    assign busy        = busy_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign tx_done     = tx_done_r;
    assign tx_error    = tx_error_r;

    // Two-flop synchronizers for both raw line levels (idle level is high).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk_in;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock deglitch: filt_clk follows the synced level only after it has differed for FILTER_LEN cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flt_cnt_r   <= {FLT_W{1'b0}};
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
        end else begin
            filt_prev_r <= filt_clk_r;
            if (clk_sync_r == filt_clk_r) begin
                flt_cnt_r <= {FLT_W{1'b0}};
            end else if (flt_cnt_r == FLT_LAST) begin
                filt_clk_r <= clk_sync_r;
                flt_cnt_r  <= {FLT_W{1'b0}};
            end else begin
                flt_cnt_r <= flt_cnt_r + {{(FLT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state, bit sequencing and next data-line enable. A fall always wins over a timeout.
    always_comb begin
        next_state_s = state_r;
        reload_s     = 1'b0;
        data_oe_nx_s = data_oe_r;
        bit_cnt_nx_s = bit_cnt_r;
        case (state_r)
            ST_IDLE: begin
                data_oe_nx_s = 1'b0;
                if (accept_s) begin
                    next_state_s = ST_INHIBIT;
                    bit_cnt_nx_s = 4'd0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (tmr_r == INH_LAST) begin
                    next_state_s = ST_REQ;
                    data_oe_nx_s = 1'b1;
                end else begin
                    next_state_s = ST_INHIBIT;
                    data_oe_nx_s = 1'b0;
                end
            end
            ST_REQ: begin
                data_oe_nx_s = 1'b1;
                if (tmr_r == REQ_LAST) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_RELEASE: begin
                if (fall_s) begin
                    next_state_s = ST_SEND;
                    data_oe_nx_s = ~sh_r[0];
                    bit_cnt_nx_s = 4'd1;
                end else if (tmr_r == START_LAST) begin
                    next_state_s = ST_ERR;
                    data_oe_nx_s = 1'b0;
                end else begin
                    next_state_s = ST_RELEASE;
                    data_oe_nx_s = 1'b1;
                end
            end
            ST_SEND: begin
                if (fall_s) begin
                    reload_s     = 1'b1;
                    data_oe_nx_s = ~sh_r[bit_cnt_r];
                    bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd9) begin
                        next_state_s = ST_ACK;
                    end else begin
                        next_state_s = ST_SEND;
                    end
                end else if (tmr_r == FRAME_LAST) begin
                    next_state_s = ST_ERR;
                    data_oe_nx_s = 1'b0;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_ACK: begin
                data_oe_nx_s = 1'b0;
                if (fall_s) begin
                    reload_s = 1'b1;
                    if (!data_sync_r) begin
                        next_state_s = ST_WAIT_IDLE;
                    end else begin
                        next_state_s = ST_ERR;
                    end
                end else if (tmr_r == FRAME_LAST) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                data_oe_nx_s = 1'b0;
                if (filt_clk_r && data_sync_r) begin
                    next_state_s = ST_DONE;
                end else if (fall_s) begin
                    reload_s     = 1'b1;
                    next_state_s = ST_WAIT_IDLE;
                end else if (tmr_r == FRAME_LAST) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_WAIT_IDLE;
                end
            end
            ST_DONE: begin
                data_oe_nx_s = 1'b0;
                next_state_s = ST_IDLE;
            end
            ST_ERR: begin
                data_oe_nx_s = 1'b0;
                next_state_s = ST_IDLE;
            end
            default: begin
                data_oe_nx_s = 1'b0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Shared phase/watchdog timer: cleared on state change or device clock fall, saturates at max.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (tmr_clear_s) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (tmr_r != TMR_MAX) begin
            tmr_r <= tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // Frame shift register {stop, parity, data} latched on acceptance, plus the bit counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_r      <= 10'h3FF;
            bit_cnt_r <= 4'd0;
        end else begin
            bit_cnt_r <= bit_cnt_nx_s;
            if (accept_s) begin
                sh_r <= {1'b1, odd_parity(tx_data), tx_data};
            end else begin
                sh_r <= sh_r;
            end
        end
    end

    // Registered outputs decoded from the next state so they line up with state_r.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            tx_done_r  <= 1'b0;
            tx_error_r <= 1'b0;
        end else begin
            tx_ready_r <= (next_state_s == ST_IDLE);
            busy_r     <= (next_state_s != ST_IDLE);
            clk_oe_r   <= (next_state_s == ST_INHIBIT) || (next_state_s == ST_REQ);
            data_oe_r  <= data_oe_nx_s;
            tx_done_r  <= (next_state_s == ST_DONE);
            tx_error_r <= (next_state_s == ST_ERR);
        end
    end

endmodule
